// File: rtl/tinker_pkg.sv
// Shared types and default widths for the Tinker memory arbiter slice.
package tinker_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 64;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Requester that owns the transaction in flight.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/tinker_mem_arbiter_if.sv
// Request/response and memory-port bundle between the core requesters,
// the arbiter and the memory array.
interface tinker_mem_arbiter_if
    import tinker_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_rsp_valid;
    logic [31:0]       if_rsp_data;
    logic              d_req_valid;
    logic              d_req_ready;
    logic              d_req_we;
    logic [ADDR_W-1:0] d_req_addr;
    logic [DATA_W-1:0] d_req_wdata;
    logic              d_rsp_valid;
    logic [DATA_W-1:0] d_rsp_data;
    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              busy;

    // Arbiter side.
    modport slave (
        input  if_req_valid, if_req_addr,
        input  d_req_valid, d_req_we, d_req_addr, d_req_wdata,
        input  m_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        output d_req_ready, d_rsp_valid, d_rsp_data,
        output m_en, m_we, m_addr, m_wdata, busy
    );

    // Requesters and memory side.
    modport master (
        output if_req_valid, if_req_addr,
        output d_req_valid, d_req_we, d_req_addr, d_req_wdata,
        output m_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        input  d_req_ready, d_rsp_valid, d_rsp_data,
        input  m_en, m_we, m_addr, m_wdata, busy
    );

endinterface

// File: rtl/tinker_arb_pick.sv
// Combinational winner selection between fetch and data requesters.
module tinker_arb_pick (
    input  logic if_valid,
    input  logic d_valid,
    input  logic starve_hit,
    output logic grant_if,
    output logic grant_d
);

    // Data has priority unless fetch has already lost the limit of rounds in a row.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (if_valid && (!d_valid || starve_hit)) begin
            grant_if = 1'b1;
        end else if (d_valid) begin
            grant_d = 1'b1;
        end else begin
            grant_if = 1'b0;
            grant_d  = 1'b0;
        end
    end

endmodule

// File: rtl/tinker_mem_arbiter.sv
// Shares one fixed-latency single-ported memory between instruction fetch
// and data load/store. One transaction at a time: accept, issue, wait for
// read data, then a one-cycle response pulse to the owner.
module tinker_mem_arbiter
    import tinker_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    tinker_mem_arbiter_if.slave  bus
);

    localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
    localparam int                WAIT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [WAIT_W-1:0] WAIT_INIT  = WAIT_W'(MEM_LAT - 1);

    arb_state_t        state_r;
    owner_t            owner_r;
    logic [CNT_W-1:0]  starve_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              m_en_r;
    logic              m_we_r;
    logic [ADDR_W-1:0] m_addr_r;
    logic [DATA_W-1:0] m_wdata_r;
    logic [DATA_W-1:0] rsp_data_r;
    logic              if_rsp_valid_r;
    logic              d_rsp_valid_r;

    logic idle_s;
    logic starve_hit_s;
    logic grant_if_s;
    logic grant_d_s;
    logic read_done_s;

    // Ready is only offered from IDLE and never while reset is held.
    assign idle_s       = (state_r == IDLE) && !reset;
    assign starve_hit_s = (starve_cnt_r == STARVE_LIM);
    assign read_done_s  = (state_r == WAIT) && (wait_cnt_r == '0);

    tinker_arb_pick u_pick (
        .if_valid   (bus.if_req_valid & idle_s),
        .d_valid    (bus.d_req_valid & idle_s),
        .starve_hit (starve_hit_s),
        .grant_if   (grant_if_s),
        .grant_d    (grant_d_s)
    );

    // State sequencing, owner capture and read-latency countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            owner_r    <= OWN_IF;
            wait_cnt_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_d_s) begin
                        owner_r <= OWN_D;
                        state_r <= ISSUE;
                    end else if (grant_if_s) begin
                        owner_r <= OWN_IF;
                        state_r <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    if (m_we_r) begin
                        state_r <= RESP;
                    end else begin
                        wait_cnt_r <= WAIT_INIT;
                        state_r    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt_r == '0) begin
                        state_r <= RESP;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - WAIT_W'(1);
                    end
                end
                RESP:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Count consecutive fetch losses; any fetch grant or idle fetch clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_r <= '0;
        end else if (idle_s) begin
            if (!bus.if_req_valid || grant_if_s) begin
                starve_cnt_r <= '0;
            end else if (grant_d_s && (starve_cnt_r != STARVE_LIM)) begin
                starve_cnt_r <= starve_cnt_r + CNT_W'(1);
            end
        end
    end

    // Memory port: strobe for the single ISSUE cycle, address/data held after.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_en_r    <= 1'b0;
            m_we_r    <= 1'b0;
            m_addr_r  <= '0;
            m_wdata_r <= '0;
        end else begin
            m_en_r <= 1'b0;
            m_we_r <= 1'b0;
            if (grant_d_s) begin
                m_en_r    <= 1'b1;
                m_we_r    <= bus.d_req_we;
                m_addr_r  <= bus.d_req_addr;
                m_wdata_r <= bus.d_req_wdata;
            end else if (grant_if_s) begin
                m_en_r   <= 1'b1;
                m_addr_r <= bus.if_req_addr;
            end
        end
    end

    // Response data and one-cycle valid pulse, raised on entry to RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_data_r     <= '0;
            if_rsp_valid_r <= 1'b0;
            d_rsp_valid_r  <= 1'b0;
        end else begin
            if_rsp_valid_r <= 1'b0;
            d_rsp_valid_r  <= 1'b0;
            if ((state_r == ISSUE) && m_we_r) begin
                rsp_data_r    <= '0;
                d_rsp_valid_r <= 1'b1;
            end else if (read_done_s) begin
                rsp_data_r     <= bus.m_rdata;
                if_rsp_valid_r <= (owner_r == OWN_IF);
                d_rsp_valid_r  <= (owner_r == OWN_D);
            end
        end
    end

    assign bus.if_req_ready = grant_if_s;
    assign bus.d_req_ready  = grant_d_s;
    assign bus.if_rsp_valid = if_rsp_valid_r;
    assign bus.if_rsp_data  = rsp_data_r[31:0];
    assign bus.d_rsp_valid  = d_rsp_valid_r;
    assign bus.d_rsp_data   = rsp_data_r;
    assign bus.m_en         = m_en_r;
    assign bus.m_we         = m_we_r;
    assign bus.m_addr       = m_addr_r;
    assign bus.m_wdata      = m_wdata_r;
    assign bus.busy         = (state_r != IDLE);

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// Scoreboard bench for tinker_mem_arbiter: drivers push expected responses,
// a monitor pops and compares whenever a response pulse appears.
module tb_tinker_mem_arbiter;
    import tinker_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic        is_if;
        logic [63:0] data;
        int          cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic [63:0] got;

    logic [63:0] mem [logic [31:0]];
    logic        rd_vld0 = 1'b0, rd_vld1 = 1'b0;
    logic [63:0] rd_dat0 = 64'h0, rd_dat1 = 64'h0;

    logic [31:0] sd_addr [8] = '{32'h3000, 32'h3008, 32'h3010, 32'h3018,
                                 32'h3020, 32'h3028, 32'h3030, 32'h3038};
    logic [63:0] sd_data [8] = '{64'hDA7A_0000_0000_0000, 64'hDA7A_0000_0000_0001,
                                 64'hDA7A_0000_0000_0002, 64'hDA7A_0000_0000_0003,
                                 64'hDA7A_0000_0000_0004, 64'hDA7A_0000_0000_0005,
                                 64'hDA7A_0000_0000_0006, 64'hDA7A_0000_0000_0007};
    int acc_d [8];
    int acc_f [2];

    tinker_mem_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus ();

    tinker_mem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (64),
        .MEM_LAT    (2),
        .STARVE_MAX (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Read data is valid only in the cycle MEM_LAT=2 after the issue cycle.
    assign bus.m_rdata = rd_vld1 ? rd_dat1 : 64'hBAD0_BAD0_BAD0_BAD0;

    property p_hold_d;
        @(posedge clk) disable iff (reset)
        (bus.d_req_valid && !bus.d_req_ready) |=>
        (bus.d_req_valid && $stable(bus.d_req_we) && $stable(bus.d_req_addr) && $stable(bus.d_req_wdata));
    endproperty
    a_hold_d: assert property (p_hold_d) else $error("data requester changed request before ready");

    property p_hold_if;
        @(posedge clk) disable iff (reset)
        (bus.if_req_valid && !bus.if_req_ready) |=> (bus.if_req_valid && $stable(bus.if_req_addr));
    endproperty
    a_hold_if: assert property (p_hold_if) else $error("fetch requester changed request before ready");

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after acceptance, valid left high.
    task automatic drive_d(input logic we, input logic [31:0] addr, input logic [63:0] wdata,
                           input logic push, input logic [63:0] exp, input string nm, output int acc);
        bus.d_req_valid = 1'b1;
        bus.d_req_we    = we;
        bus.d_req_addr  = addr;
        bus.d_req_wdata = wdata;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (bus.d_req_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: got no d_req_ready in 200 cycles, required acceptance", nm);
            bus.d_req_valid = 1'b0;
        end else begin
            if (push) exp_q.push_back('{is_if: 1'b0, data: exp, cyc: acc + (we ? 2 : 4), name: nm});
            @(negedge clk);
        end
    endtask

    task automatic drive_if(input logic [31:0] addr, input logic push, input logic [63:0] exp,
                            input string nm, output int acc);
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = addr;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (bus.if_req_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: got no if_req_ready in 200 cycles, required acceptance", nm);
            bus.if_req_valid = 1'b0;
        end else begin
            if (push) exp_q.push_back('{is_if: 1'b1, data: exp, cyc: acc + 4, name: nm});
            @(negedge clk);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_if_ready"}, 64'(bus.if_req_ready), 64'd0);
        chk({nm, "_d_ready"},  64'(bus.d_req_ready),  64'd0);
        chk({nm, "_if_rsp_v"}, 64'(bus.if_rsp_valid), 64'd0);
        chk({nm, "_if_rsp_d"}, 64'(bus.if_rsp_data),  64'd0);
        chk({nm, "_d_rsp_v"},  64'(bus.d_rsp_valid),  64'd0);
        chk({nm, "_d_rsp_d"},  bus.d_rsp_data,        64'd0);
        chk({nm, "_m_en"},     64'(bus.m_en),         64'd0);
        chk({nm, "_m_we"},     64'(bus.m_we),         64'd0);
        chk({nm, "_m_addr"},   64'(bus.m_addr),       64'd0);
        chk({nm, "_m_wdata"},  bus.m_wdata,           64'd0);
        chk({nm, "_busy"},     64'(bus.busy),         64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc_a, acc_b, r;
        reset            = 1'b1;
        bus.if_req_valid = 1'b0;
        bus.if_req_addr  = 32'h0;
        bus.d_req_valid  = 1'b0;
        bus.d_req_we     = 1'b0;
        bus.d_req_addr   = 32'h0;
        bus.d_req_wdata  = 64'h0;
        mem[32'h2000] = 64'hDEADBEEF_00000001;
        mem[32'h2004] = 64'h12345678_9ABCDEF0;
        mem[32'h4000] = 64'hFFFF_0000_F00D_0001;
        mem[32'h4004] = 64'hFFFF_0000_F00D_0002;
        for (int i = 0; i < 8; i++) mem[sd_addr[i]] = sd_data[i];

        fork
            // Memory model: stores commit at ISSUE, reads come back two cycles later.
            forever begin
                @(posedge clk);
                rd_vld0 <= bus.m_en && !bus.m_we;
                rd_dat0 <= mem.exists(bus.m_addr) ? mem[bus.m_addr] : 64'h0;
                rd_vld1 <= rd_vld0;
                rd_dat1 <= rd_dat0;
                if (bus.m_en && bus.m_we) mem[bus.m_addr] = bus.m_wdata;
            end
            // Response monitor.
            forever begin
                @(negedge clk);
                if (bus.if_rsp_valid || bus.d_rsp_valid) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rsp: got if_rsp_valid=%0b d_rsp_valid=%0b at cycle %0d, required no response",
                                 bus.if_rsp_valid, bus.d_rsp_valid, cyc);
                    end else begin
                        cur = exp_q.pop_front();
                        got = cur.is_if ? {32'h0, bus.if_rsp_data} : bus.d_rsp_data;
                        if ((bus.if_rsp_valid !== cur.is_if) || (bus.d_rsp_valid !== !cur.is_if) ||
                            (got !== cur.data) || ((cur.cyc >= 0) && (cur.cyc != cyc))) begin
                            errors++;
                            $display("FAIL %s: got if_v=%0b d_v=%0b data=%h cycle=%0d, required is_if=%0b data=%h cycle=%0d",
                                     cur.name, bus.if_rsp_valid, bus.d_rsp_valid, got, cyc, cur.is_if, cur.data, cur.cyc);
                        end
                    end
                end
            end
        join_none

        // Reset values, and no ready while reset is held even with requests pending.
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        bus.d_req_valid  = 1'b1;
        bus.d_req_addr   = 32'h2000;
        bus.if_req_valid = 1'b1;
        bus.if_req_addr  = 32'h2004;
        #1;
        chk("reset_gate_d_ready",  64'(bus.d_req_ready),  64'd0);
        chk("reset_gate_if_ready", 64'(bus.if_req_ready), 64'd0);

        // Simultaneous requests at reset release: data first, fetch after data RESP.
        @(negedge clk);
        reset = 1'b0;
        r = cyc;
        fork
            begin
                drive_d(1'b0, 32'h2000, 64'h0, 1'b1, 64'hDEADBEEF_00000001, "load_2000", acc_a);
                bus.d_req_valid = 1'b0;
            end
            begin
                drive_if(32'h2004, 1'b1, 64'h0000_0000_9ABC_DEF0, "fetch_2004", acc_b);
                bus.if_req_valid = 1'b0;
            end
        join
        chk("sim_d_accept_cycle",  64'(acc_a), 64'(r));
        chk("sim_if_accept_cycle", 64'(acc_b), 64'(r + 5));
        repeat (5) @(negedge clk);

        // Store: memory strobe at T+1, ack with zero data at T+2.
        drive_d(1'b1, 32'h0001_0000, 64'h55, 1'b1, 64'h0, "store_10000", acc_a);
        chk("store_m_en",    64'(bus.m_en),   64'd1);
        chk("store_m_we",    64'(bus.m_we),   64'd1);
        chk("store_m_addr",  64'(bus.m_addr), 64'h1_0000);
        chk("store_m_wdata", bus.m_wdata,     64'h55);
        bus.d_req_valid = 1'b0;
        @(negedge clk);
        chk("store_m_en_drop", 64'(bus.m_en), 64'd0);
        chk("store_busy",      64'(bus.busy), 64'd1);
        @(negedge clk);

        // Load back the stored word.
        drive_d(1'b0, 32'h0001_0000, 64'h0, 1'b1, 64'h55, "load_10000", acc_a);
        chk("load_m_en",   64'(bus.m_en),   64'd1);
        chk("load_m_we",   64'(bus.m_we),   64'd0);
        chk("load_m_addr", 64'(bus.m_addr), 64'h1_0000);
        bus.d_req_valid = 1'b0;
        repeat (6) @(negedge clk);

        // Starvation: both held valid -> D D D D F D D D D F.
        for (int i = 0; i < 4; i++) exp_q.push_back('{is_if: 1'b0, data: sd_data[i], cyc: -1, name: "starve_d"});
        exp_q.push_back('{is_if: 1'b1, data: 64'h0000_0000_F00D_0001, cyc: -1, name: "starve_f0"});
        for (int i = 4; i < 8; i++) exp_q.push_back('{is_if: 1'b0, data: sd_data[i], cyc: -1, name: "starve_d"});
        exp_q.push_back('{is_if: 1'b1, data: 64'h0000_0000_F00D_0002, cyc: -1, name: "starve_f1"});
        fork
            begin : d_thr
                int a;
                for (int i = 0; i < 8; i++) begin
                    drive_d(1'b0, sd_addr[i], 64'h0, 1'b0, 64'h0, "starve_d", a);
                    acc_d[i] = a;
                end
                bus.d_req_valid = 1'b0;
            end
            begin : f_thr
                int b;
                drive_if(32'h4000, 1'b0, 64'h0, "starve_f0", b);
                acc_f[0] = b;
                drive_if(32'h4004, 1'b0, 64'h0, "starve_f1", b);
                acc_f[1] = b;
                bus.if_req_valid = 1'b0;
            end
        join
        chk("starve_d1_after_d0", 64'(acc_d[1]), 64'(acc_d[0] + 5));
        chk("starve_f0_after_d3", 64'(acc_f[0]), 64'(acc_d[3] + 5));
        chk("starve_d4_after_f0", 64'(acc_d[4]), 64'(acc_f[0] + 5));
        chk("starve_f1_after_d7", 64'(acc_f[1]), 64'(acc_d[7] + 5));
        repeat (6) @(negedge clk);

        // Reset during WAIT: load abandoned, outputs cleared, fetch accepted right after.
        drive_d(1'b0, 32'h2000, 64'h0, 1'b0, 64'h0, "abandon", acc_a);
        bus.d_req_valid = 1'b0;
        @(negedge clk);
        chk("abandon_busy_wait", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        @(negedge clk);
        reset = 1'b0;
        r = cyc;
        drive_if(32'h2004, 1'b1, 64'h0000_0000_9ABC_DEF0, "fetch_after_rst", acc_b);
        bus.if_req_valid = 1'b0;
        chk("fetch_after_rst_cycle", 64'(acc_b), 64'(r));
        repeat (8) @(negedge clk);

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tinker_mem_arbiter.md
# tinker_mem_arbiter

Shares one single-ported, fixed-latency memory between the Tinker instruction-fetch requester and the data load/store requester. It sits between the core's fetch/control logic and the memory array. It accepts one valid/ready request at a time, sequences the memory port through issue and wait phases, and returns a one-cycle response pulse to the winning requester. Data requests normally win arbitration; a starvation counter guarantees that fetch makes forward progress.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 64, data word width
- MEM_LAT, 2, cycles from the m_en issue cycle to m_rdata being valid; must be ≥1
- STARVE_MAX, 4, number of consecutive lost arbitrations after which fetch is forced to win

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  ADDR_W  fetch address
- if_rsp_valid  out  1  fetch response pulse
- if_rsp_data  out  32  instruction, taken from m_rdata[31:0]
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted this cycle
- d_req_we  in  1  1 = store, 0 = load
- d_req_addr  in  ADDR_W  data address
- d_req_wdata  in  DATA_W  store data
- d_rsp_valid  out  1  data response pulse (load data, or store acknowledge)
- d_rsp_data  out  DATA_W  load data; 0 for stores
- m_en  out  1  memory access strobe
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data
- busy  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Picks a winner among the valid requesters and asserts that requester's ready combinationally. Only one ready is ever high.
  - On valid&ready, registers the address, we and wdata, plus the owner ID, then moves to ISSUE.
- ISSUE (1 cycle):
  - Drives m_en=1, m_we=owner_we, and the registered m_addr/m_wdata.
  - Store: goes to RESP.
  - Load or fetch: loads wait_cnt=MEM_LAT-1, then goes to WAIT. If MEM_LAT=1, WAIT lasts exactly one cycle.
- WAIT: decrements wait_cnt. When wait_cnt reaches 0, captures m_rdata into the response register and moves to RESP.
- RESP (1 cycle): asserts the owner's rsp_valid with the registered data, then returns to IDLE.
- Arbitration:
  - Only d valid → data wins. Only if valid → fetch wins. Neither valid → no ready.
  - Both valid → data wins, unless starve_cnt == STARVE_MAX, in which case fetch wins.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each IDLE cycle where fetch is valid and data wins.
  - Clears when fetch is granted, or on any IDLE cycle where if_req_valid=0.
- Requester rule: valid, addr, we and wdata hold stable until ready. Violations are the requester's fault; the bench asserts this rule.
- Addresses pass through unmodified. No alignment check and no wrap logic.
- Reset value of every output: ready=0, rsp_valid=0, rsp_data=0, m_en=0, m_we=0, m_addr=0, m_wdata=0, busy=0.
- Reset of internal state: state=IDLE, starve_cnt=0, wait_cnt=0.
- Reset mid-transaction: the transaction is abandoned and no response is produced. A store that already issued in ISSUE remains committed in memory.

## Timing
- Handshake accepted in cycle T.
- ISSUE occurs in cycle T+1.
- Load/fetch:
  - m_rdata is sampled at the end of cycle T+1+MEM_LAT.
  - rsp_valid is high in cycle T+2+MEM_LAT.
  - With MEM_LAT=2, the response arrives at T+4.
- Store: rsp_valid is high in cycle T+2.
- IDLE resumes the cycle after RESP. This gives the next possible accept at T+3+MEM_LAT (load/fetch) or T+3 (store).
- rsp_valid is always exactly one cycle wide. The requester has no backpressure on the response.
- The m_* outputs are registered. m_en is high only in ISSUE. m_addr/m_wdata hold their last values outside ISSUE.

## Structure
- tinker_pkg holds:
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP}
  - owner_t enum {OWN_IF, OWN_D}
  - ADDR_W/DATA_W defaults
- One combinational sub-module, tinker_arb_pick:
  - Inputs: if_valid, d_valid, starve_cnt==STARVE_MAX.
  - Outputs: grant_if, grant_d.
- The FSM, counters and registers live in tinker_mem_arbiter.

## Test plan
- Single load: d_req at 0x2000 with m_rdata=0xDEADBEEF_00000001, MEM_LAT=2 → m_en in cycle T+1; d_rsp_valid for exactly one cycle at T+4 with that data.
- Store: d_req_we=1, addr 0x10000, wdata 0x55 → m_en=m_we=1 at T+1 with 0x10000/0x55; d_rsp_valid at T+2 with data 0; if_rsp_valid never asserts.
- Fetch: if_req at 0x2004 with m_rdata=0x1234_5678_9ABC_DEF0 → if_rsp_data=0x9ABCDEF0 at T+4.
- Starvation: both requesters held valid continuously with STARVE_MAX=4 → 4 data grants, then 1 fetch grant; the pattern repeats with at most 4 data grants between fetch grants.
- Simultaneous valid at reset release with starve_cnt=0 → data granted first; if_req_ready stays 0 until data RESP completes.
- Reset asserted during WAIT → next cycle all outputs are 0 and state is IDLE; no rsp_valid for the abandoned load; a new fetch is accepted the first cycle after reset deasserts.
